// File: rtl/apb_arb_master.sv
// Round-robin arbitrated APB master: NREQ requesters share one APB slave port.
// Latency: request sampled at edge 0, SETUP cycle 1, ACCESS from cycle 2, rsp_valid the cycle after ACCESS ends.
// Backpressure: pready=0 extends ACCESS; the optional timeout aborts the transfer with rsp_err=1.
module apb_arb_master #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ack,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [31:0]      paddr,
  output logic [31:0]      pwdata,
  input  logic [31:0]      prdata,
  input  logic             pready,
  input  logic             pslverr
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant, last_grant_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;

  logic [NREQ-1:0] req_ack_nxt, rsp_valid_nxt;
  logic [31:0]     rsp_rdata_nxt, paddr_nxt, pwdata_nxt;
  logic            rsp_err_nxt, psel_nxt, penable_nxt, pwrite_nxt;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;

  // Returns {found, index}: first valid requester searching upward from last+1.
  // Scanning from the farthest offset down leaves the nearest hit as the result.
  function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] v, input logic [GW-1:0] last);
    logic [GW:0] r;
    int          idx;
    r = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (v[idx]) r = {1'b1, GW'(idx)};
    end
    return r;
  endfunction

  // Round-robin selection among the current requests.
  always_comb begin
    {pick_found, pick_idx} = rr_pick(req_valid, last_grant);
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = '0;
    req_ack_nxt    = '0;
    rsp_valid_nxt  = '0;
    rsp_rdata_nxt  = '0;
    rsp_err_nxt    = 1'b0;
    psel_nxt       = 1'b0;
    penable_nxt    = 1'b0;
    pwrite_nxt     = pwrite;
    paddr_nxt      = paddr;
    pwdata_nxt     = pwdata;

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt             = SETUP;
          last_grant_nxt        = pick_idx;
          req_ack_nxt[pick_idx] = 1'b1;
          psel_nxt              = 1'b1;
          pwrite_nxt            = req_write[pick_idx];
          paddr_nxt             = req_addr[int'(pick_idx)*32 +: 32];
          pwdata_nxt            = req_wdata[int'(pick_idx)*32 +: 32];
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_nxt                 = IDLE;
          rsp_valid_nxt[last_grant] = 1'b1;
          rsp_err_nxt               = pslverr;
          rsp_rdata_nxt             = pwrite ? 32'd0 : prdata;
        end else if (TIMEOUT_CYC > 0 && wait_cnt == CW'(TIMEOUT_CYC)) begin
          // Hung slave: release the bus and report an error with no data.
          state_nxt                 = IDLE;
          rsp_valid_nxt[last_grant] = 1'b1;
          rsp_err_nxt               = 1'b1;
        end else begin
          psel_nxt     = 1'b1;
          penable_nxt  = 1'b1;
          wait_cnt_nxt = (TIMEOUT_CYC > 0) ? wait_cnt + CW'(1) : '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any transfer in flight.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state      <= IDLE;
      last_grant <= GW'(NREQ - 1);
      wait_cnt   <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
      req_ack    <= req_ack_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      psel       <= psel_nxt;
      penable    <= penable_nxt;
      pwrite     <= pwrite_nxt;
      paddr      <= paddr_nxt;
      pwdata     <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master (NREQ=2, TIMEOUT_CYC=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_apb_arb_master;

  logic        pclk;
  logic        preset;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ack;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  apb_arb_master #(.NREQ(2), .TIMEOUT_CYC(4)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
    tick(); tick();
    checks++;
    if ({psel, penable, pwrite, req_ack, rsp_valid, rsp_err} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000", {psel, penable, pwrite, req_ack, rsp_valid, rsp_err});
    end
    checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'd0) begin
      errors++; $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want all 0", paddr, pwdata, rsp_rdata);
    end
    preset = 1'b1;
    tick();
    checks++;
    if ({psel, req_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got %b want 000", {psel, req_ack});
    end
  endtask

  // Both requesters hold valid throughout: grants must alternate 0,1,0,1.
  task automatic test_round_robin();
    logic [1:0]  exp_oh;
    logic [31:0] exp_d;
    req_write = 2'b11;
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_wdata = {32'h0000_000B, 32'h0000_000A};
    pready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d  = (i % 2 == 0) ? 32'hA : 32'hB;
      tick();
      checks++;
      if ({psel, penable, pwrite, req_ack} !== {3'b101, exp_oh}) begin
        errors++; $display("FAIL rr_setup[%0d]: psel/pen/pwr/ack=%b want %b", i, {psel, penable, pwrite, req_ack}, {3'b101, exp_oh});
      end
      checks++;
      if (pwdata !== exp_d) begin
        errors++; $display("FAIL rr_pwdata[%0d]: got %h want %h", i, pwdata, exp_d);
      end
      tick();
      tick();
      checks++;
      if ({psel, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, exp_oh, 1'b0, 32'd0}) begin
        errors++; $display("FAIL rr_rsp[%0d]: psel=%b rsp_valid=%b err=%b rdata=%h want 0 %b 0 0", i, psel, rsp_valid, rsp_err, rsp_rdata, exp_oh);
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single_read();
    req_write = 2'b00;
    req_addr  = {32'h0, 32'h0000_0010};
    pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    checks++;
    if ({psel, penable, pwrite, req_ack, rsp_valid} !== 7'b1000100) begin
      errors++; $display("FAIL rd_setup: got %b want 1000100", {psel, penable, pwrite, req_ack, rsp_valid});
    end
    checks++;
    if (paddr !== 32'h10) begin
      errors++; $display("FAIL rd_paddr: got %h want 00000010", paddr);
    end
    tick();
    checks++;
    if ({psel, penable, req_ack, rsp_valid} !== 6'b110000) begin
      errors++; $display("FAIL rd_access: got %b want 110000", {psel, penable, req_ack, rsp_valid});
    end
    tick();
    checks++;
    if ({psel, penable, rsp_valid, rsp_err} !== 5'b00010) begin
      errors++; $display("FAIL rd_rsp_ctrl: got %b want 00010", {psel, penable, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_rdata: got %h want deadbeef", rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++; $display("FAIL rd_rsp_pulse: got %b want 00", rsp_valid);
    end
  endtask

  // Requester 1 write; pready low for the first three ACCESS cycles.
  task automatic test_wait_states();
    req_write = 2'b10;
    req_addr  = {32'h0000_0300, 32'h0};
    req_wdata = {32'h0000_55AA, 32'h0};
    pready = 1'b0; prdata = 32'h1111_2222;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    checks++;
    if (req_ack !== 2'b10) begin
      errors++; $display("FAIL ws_ack: got %b want 10", req_ack);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {3'b111, 32'h300, 32'h55AA, 2'b00}) begin
        errors++; $display("FAIL ws_hold[%0d]: sel/en/wr=%b addr=%h wdata=%h rsp=%b want 111 300 55aa 00",
                           j, {psel, penable, pwrite}, paddr, pwdata, rsp_valid);
      end
      if (j == 3) pready = 1'b1;
      tick();
    end
    checks++;
    if ({psel, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 2'b10, 1'b0, 32'd0}) begin
      errors++; $display("FAIL ws_rsp: psel=%b rsp=%b err=%b rdata=%h want 0 10 0 0", psel, rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  // Requester 0 read against a stuck slave: counter reaches 4, then abort.
  task automatic test_timeout();
    req_write = 2'b00;
    req_addr  = {32'h0, 32'h0000_0400};
    pready = 1'b0; prdata = 32'hCAFE_F00D;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    for (int j = 0; j < 5; j++) begin
      checks++;
      if ({psel, penable, rsp_valid} !== 4'b1100) begin
        errors++; $display("FAIL to_wait[%0d]: got %b want 1100", j, {psel, penable, rsp_valid});
      end
      tick();
    end
    checks++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b1, 32'd0}) begin
      errors++; $display("FAIL to_abort: sel/en=%b rsp=%b err=%b rdata=%h want 00 01 1 0", {psel, penable}, rsp_valid, rsp_err, rsp_rdata);
    end
    pready = 1'b1;
  endtask

  task automatic test_slverr();
    req_write = 2'b00;
    req_addr  = {32'h0000_0500, 32'h0};
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h1234_5678;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL slverr_rsp: rsp=%b err=%b rdata=%h want 10 1 12345678", rsp_valid, rsp_err, rsp_rdata);
    end
    pslverr = 1'b0;
  endtask

  // Reset during requester 0's ACCESS; afterwards requester 0 must still win first.
  task automatic test_reset_mid();
    req_write = 2'b00;
    req_addr  = {32'h0000_0700, 32'h0000_0600};
    pready = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: got %b want 11", {psel, penable});
    end
    preset = 1'b0;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, req_ack} !== 6'b0) begin
      errors++; $display("FAIL rst_async: got %b want 000000", {psel, penable, rsp_valid, req_ack});
    end
    tick();
    preset = 1'b1;
    pready = 1'b1;
    tick();
    checks++;
    if ({psel, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_no_rsp: got %b want 000", {psel, rsp_valid});
    end
    req_valid = 2'b11;
    tick();
    req_valid = 2'b10;
    checks++;
    if ({req_ack, paddr} !== {2'b01, 32'h600}) begin
      errors++; $display("FAIL rst_regrant: ack=%b paddr=%h want 01 00000600", req_ack, paddr);
    end
    tick();
    tick();
    tick();
    req_valid = 2'b00;
    checks++;
    if (req_ack !== 2'b10) begin
      errors++; $display("FAIL rst_next: ack=%b want 10", req_ack);
    end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
